// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      ERR   = 2'd2
   } state_e;

   localparam int unsigned MAX_WAIT_DEF = 255;
   localparam int unsigned REG_W        = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // A load in EX feeding either source operand of the instruction in ID.
   function automatic logic load_use_hazard(input logic             memread,
                                            input logic [REG_W-1:0] rd,
                                            input logic [REG_W-1:0] rs1,
                                            input logic [REG_W-1:0] rs2);
      return memread && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, memory handshake and pipeline-register controls.
interface pipeline_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic             idex_memread_i;
   logic [REG_W-1:0] idex_rd_i;
   logic [REG_W-1:0] ifid_rs1_i;
   logic [REG_W-1:0] ifid_rs2_i;
   logic             branch_taken_i;
   logic             dmem_req_i;
   logic             dmem_ack_i;
   logic             dmem_start_o;
   logic             stall_o;
   logic             pc_write_o;
   logic             ifid_write_o;
   logic             ifid_flush_o;
   logic             idex_bubble_o;
   logic             err_o;

   modport master (
      output idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
             branch_taken_i, dmem_req_i, dmem_ack_i,
      input  dmem_start_o, stall_o, pc_write_o, ifid_write_o,
             ifid_flush_o, idex_bubble_o, err_o
   );

   modport slave (
      input  idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
             branch_taken_i, dmem_req_i, dmem_ack_i,
      output dmem_start_o, stall_o, pc_write_o, ifid_write_o,
             ifid_flush_o, idex_bubble_o, err_o
   );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Pair of free-running wrap counters for stall cycles and IF/ID flushes.
module pipe_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_inc_i,
   input  logic             flush_inc_i,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o
);

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc_i) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc_i) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles_o = stall_cnt_q;
   assign flush_count_o  = flush_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller with data-memory wait and timeout tracking.
// Define PIPE_CTRL_PERF_EN to add the stall-cycle and flush performance counters.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
`ifdef PIPE_CTRL_PERF_EN
   ,parameter int unsigned CNT_W   = 32
`endif
) (
   input  logic           clk_i,
   input  logic           rst_i,
   pipeline_ctrl_if.slave ctrl
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0]  flush_count_o
`endif
);

   localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_stall;
   logic              start_fsm;
   logic              err_fsm;
   logic              load_use;

   // Memory handshake sequencing; an ack in the timeout cycle still wins.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_stall  = 1'b0;
      start_fsm  = 1'b0;
      err_fsm    = 1'b0;
      case (state_q)
         RUN: begin
            if (ctrl.dmem_req_i) begin
               start_fsm  = 1'b1;
               mem_stall  = 1'b1;
               wait_cnt_d = '0;
               state_d    = DWAIT;
            end
         end
         DWAIT: begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (ctrl.dmem_ack_i) begin
               state_d = RUN;
            end else begin
               mem_stall = 1'b1;
               if (wait_cnt_q == WAIT_LAST) state_d = ERR;
            end
         end
         ERR: begin
            mem_stall = 1'b1;
            err_fsm   = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign load_use = load_use_hazard(ctrl.idex_memread_i, ctrl.idex_rd_i,
                                     ctrl.ifid_rs1_i, ctrl.ifid_rs2_i);

   // Reset drains the pipeline; otherwise stall > load-use > branch.
   always_comb begin
      ctrl.stall_o       = mem_stall;
      ctrl.pc_write_o    = 1'b1;
      ctrl.ifid_write_o  = 1'b1;
      ctrl.ifid_flush_o  = 1'b0;
      ctrl.idex_bubble_o = 1'b0;
      ctrl.dmem_start_o  = start_fsm;
      ctrl.err_o         = err_fsm;
      if (rst_i) begin
         ctrl.stall_o       = 1'b1;
         ctrl.pc_write_o    = 1'b0;
         ctrl.ifid_write_o  = 1'b0;
         ctrl.ifid_flush_o  = 1'b1;
         ctrl.idex_bubble_o = 1'b1;
         ctrl.dmem_start_o  = 1'b0;
         ctrl.err_o         = 1'b0;
      end else if (mem_stall) begin
         ctrl.pc_write_o   = 1'b0;
         ctrl.ifid_write_o = 1'b0;
      end else if (load_use) begin
         ctrl.pc_write_o    = 1'b0;
         ctrl.ifid_write_o  = 1'b0;
         ctrl.idex_bubble_o = 1'b1;
      end else if (ctrl.branch_taken_i) begin
         ctrl.ifid_flush_o = 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .stall_inc_i    (!rst_i && (ctrl.stall_o || ctrl.idex_bubble_o)),
      .flush_inc_i    (!rst_i && ctrl.ifid_flush_o),
      .stall_cycles_o (stall_cycles_o),
      .flush_count_o  (flush_count_o)
   );
`endif

endmodule
